// File: rtl/writeback_arbiter.sv
// Writeback merge of the in-order ALU path and a FIFO-buffered long-latency path onto one
// register-file write port, with a pending-destination scoreboard that raises the decode hazard.
module writeback_arbiter #(
  parameter int XLEN         = 32,
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            alu_valid,
  input  logic [4:0]      alu_rd_addr,
  input  logic [XLEN-1:0] alu_data,
  output logic            alu_stall,
  input  logic            lsu_valid,
  output logic            lsu_ready,
  input  logic [4:0]      lsu_rd_addr,
  input  logic [XLEN-1:0] lsu_data,
  input  logic            issue_valid,
  input  logic [4:0]      issue_rd_addr,
  input  logic [4:0]      dec_rs1_addr,
  input  logic [4:0]      dec_rs2_addr,
  input  logic [4:0]      dec_rd_addr,
  output logic            hazard,
  output logic [4:0]      wb_rd_addr,
  output logic [XLEN-1:0] wb_data
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [4:0]      fifo_rd   [FIFO_DEPTH];
  logic [XLEN-1:0] fifo_dat  [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic [SW-1:0]   starve_cnt, starve_next;
  logic [31:0]     pending, pending_next;
  logic            wb_from_lsu;
  logic            empty, full, push, pop, alu_win;

  assign empty     = (count == '0);
  assign full      = (count == CW'(FIFO_DEPTH));
  assign lsu_ready = !full;
  assign push      = lsu_valid && !full;

  // alu_valid is ignored while stalled; any cycle the ALU does not win, a waiting head pops.
  assign alu_win = !alu_stall && alu_valid && (alu_rd_addr != 5'd0);
  assign pop     = !empty && !alu_win;

  always_comb begin
    starve_next = starve_cnt;
    if (pop || empty)
      starve_next = '0;
    else if (alu_win && (starve_cnt < SW'(STARVE_LIMIT)))
      starve_next = starve_cnt + SW'(1);
  end

  always_comb begin
    pending_next = pending;
    if (wb_from_lsu)
      pending_next[wb_rd_addr] = 1'b0;
    if (issue_valid)
      pending_next[issue_rd_addr] = 1'b1;
    pending_next[0] = 1'b0;
  end

  assign hazard = pending[dec_rs1_addr] | pending[dec_rs2_addr] | pending[dec_rd_addr];

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd[wr_ptr]  <= lsu_rd_addr;
      fifo_dat[wr_ptr] <= lsu_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      starve_cnt  <= '0;
      alu_stall   <= 1'b0;
      pending     <= '0;
      wb_from_lsu <= 1'b0;
      wb_rd_addr  <= 5'd0;
      wb_data     <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count       <= count + CW'(push) - CW'(pop);
      starve_cnt  <= starve_next;
      alu_stall   <= (starve_next == SW'(STARVE_LIMIT));
      pending     <= pending_next;
      wb_from_lsu <= pop;
      if (pop) begin
        wb_rd_addr <= fifo_rd[rd_ptr];
        wb_data    <= fifo_dat[rd_ptr];
      end else if (alu_win) begin
        wb_rd_addr <= alu_rd_addr;
        wb_data    <= alu_data;
      end else begin
        wb_rd_addr <= 5'd0;
      end
    end
  end
endmodule

// File: doc/writeback_arbiter.md
# writeback_arbiter

Writeback stage that produces the single register-file write port (`rd_addr`/`data`, `rd_addr == 0` meaning no write) for the core. It merges two result sources:
- the in-order single-cycle ALU path;
- a long-latency path (loads, mul/div) that returns results out of band through a valid/ready handshake into a small FIFO.

It also keeps a scoreboard of destination registers with long-latency results outstanding and raises a combinational hazard to decode.

## Interface
Parameters:
- `XLEN`, 32, datapath width (matches `pipeline::XLEN`)
- `FIFO_DEPTH`, 2, long-latency result buffer entries (power of two, ≥2)
- `STARVE_LIMIT`, 4, consecutive cycles the FIFO head may be blocked by ALU writes before it is forced through

Ports:
- `clk`  in  1  clock, all state on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `alu_valid`  in  1  ALU result present this cycle
- `alu_rd_addr`  in  5  ALU destination
- `alu_data`  in  XLEN  ALU result
- `alu_stall`  out  1  upstream must hold its ALU result; `alu_valid` is ignored while high
- `lsu_valid`  in  1  long-latency result offered
- `lsu_ready`  out  1  FIFO not full
- `lsu_rd_addr`  in  5  long-latency destination
- `lsu_data`  in  XLEN  long-latency result
- `issue_valid`  in  1  long-latency op issued this cycle; marks its destination pending
- `issue_rd_addr`  in  5  destination of the issued op
- `dec_rs1_addr`, `dec_rs2_addr`, `dec_rd_addr`  in  5 each  operands of the instruction in decode
- `hazard`  out  1  decode must stall
- `wb_rd_addr`  out  5  register-file write address, registered
- `wb_data`  out  XLEN  register-file write data, registered

## Operation
- **Reset.** Reset is asynchronous on `rst_n` low and clears:
  - `wb_rd_addr` = 0 and `wb_data` = 0;
  - the FIFO (empty, so `lsu_ready` = 1);
  - all scoreboard pending bits;
  - the starvation counter (so `alu_stall` = 0).
  
  With the scoreboard clear, `hazard` = 0. Reset mid-transfer drops all buffered results.
- **FIFO push.** An entry is pushed on `lsu_valid && lsu_ready`. `lsu_ready` = !full, with no same-cycle pop-through.
- **Source selection each cycle, in priority order:**
  1. `alu_stall` = 1 and FIFO non-empty: pop FIFO head to writeback.
  2. `alu_valid` = 1 and `alu_rd_addr` != 0: ALU to writeback.
  3. FIFO non-empty: pop head.
  4. Otherwise: `wb_rd_addr` ← 0 (bubble).
- **x0 writes.** An ALU result with rd = 0 is a no-op and does not block the FIFO. A FIFO entry with rd = 0 is popped and written as a no-op.
- **Starvation counter.**
  - Increments each cycle the FIFO is non-empty and the ALU wins.
  - Resets to 0 on any pop or when the FIFO is empty.
  - `alu_stall` is registered: it is 1 in the cycle after the counter reaches `STARVE_LIMIT`, and drops after that pop.
- **Scoreboard.** Thirty-one pending bits, one per x1..x31.
  - Set on `issue_valid` with rd != 0.
  - Cleared on the edge at which a FIFO-sourced value is presented on `wb_rd_addr`, i.e. the edge the register file commits it. A tracked `wb_from_lsu` flag marks these.
  - Simultaneous set and clear of the same bit: set wins.
- **Hazard.** `hazard` = pending[rs1] | pending[rs2] | pending[rd] for the decode operands (combinational), with x0 excluded.
  - This covers RAW and WAW, so an ALU write to a pending register, or a re-issue to one, never occurs.
  - Results returning through the FIFO for registers that are not pending are legal and written as-is.

## Timing
- **ALU latency.** ALU result at cycle N appears on `wb_*` in N+1 and is committed to the register file at the edge ending N+1.
- **Long-latency latency.** A result accepted at edge E is at the FIFO head in the cycle after E. Its minimum latency to `wb_*` is therefore 1 cycle after acceptance when the ALU is idle.
- **Hazard release.** The pending bit clears at the same edge the register file writes, so `hazard` falls in the cycle in which a register-file read returns the new value.
- **Full FIFO.** `lsu_ready` falls in the cycle after the push that fills the FIFO. It rises in the cycle after a pop.
- **Worst-case drain.** The FIFO head waits at most `STARVE_LIMIT` + 1 cycles.

## Test plan
- **ALU only.** ALU writes x5=0xDEADBEEF at cycle 10 -> `wb_rd_addr`=5 and `wb_data`=0xDEADBEEF in cycle 11, then `wb_rd_addr`=0 in cycle 12 with `alu_valid` low.
- **Issue, hazard, return.** Issue rd=7 with decode rs1=7 -> `hazard`=1. Return lsu x7=0x1234 with the ALU idle -> wb x7 one cycle after acceptance, `hazard`=0 the cycle after that, and decode rs2=7 then reads 0x1234.
- **Starvation.** `alu_valid` held high (rd=3) for 10 cycles with one FIFO entry x9 -> `alu_stall`=1 after 4 blocked cycles, x9 written next, then the ALU resumes and `alu_stall`=0.
- **Backpressure.** Three back-to-back lsu offers while the ALU is busy -> two accepted, `lsu_ready`=0, the third is accepted only after a pop, and all three are written in order.
- **x0 handling.** ALU rd=0 and issue rd=0 -> no write, no pending bit set, and a waiting FIFO entry pops in that cycle.
- **Reset mid-transfer.** Assert `rst_n`=0 mid-transfer with the FIFO full and bits pending -> outputs 0 immediately, `lsu_ready`=1, `hazard`=0, and no stale writeback after release.
